// File: rtl/fatori_rst_ctrl.sv
// Core reset sequencer: stretches reset requests to HOLD_CYCLES and counts resets.
// Define FATORI_RST_CTRL_LOCKOUT_EN to lock the core in reset after MAX_RESETS consecutive resets.
module fatori_rst_ctrl #(
   parameter int unsigned HOLD_CYCLES  = 16,
   parameter int unsigned MAX_RESETS   = 3,
   parameter int unsigned QUIET_CYCLES = 1024
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       core_reset_req_i,
   input  logic       sw_reset_req_i,
   input  logic       clr_lockout_i,
   output logic       core_rst_no,
   output logic       rst_active_o,
   output logic [7:0] reset_cnt_o,
   output logic [3:0] consec_cnt_o,
   output logic       lockout_o
);

   localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned QUIET_W  = $clog2(QUIET_CYCLES + 1);
   localparam int unsigned RST_W    = 8;
   localparam int unsigned CONSEC_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_LOCK    = 2'd3;

`ifdef FATORI_RST_CTRL_LOCKOUT_EN
   localparam bit LOCKOUT_EN = 1'b1;
   logic w_clr;
   assign w_clr = clr_lockout_i;
`else
   localparam bit LOCKOUT_EN = 1'b0;
   logic w_clr;
   logic w_unused_clr;
   assign w_clr        = 1'b0;
   assign w_unused_clr = clr_lockout_i;
`endif

   logic [1:0]          r_state;
   logic [1:0]          w_state_next;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [QUIET_W-1:0]  r_quiet_cnt;
   logic [RST_W-1:0]    r_reset_cnt;
   logic [CONSEC_W-1:0] r_consec_cnt;
   logic                w_req;
   logic                w_hold_done;
   logic                w_lock_hit;
   logic                w_quiet_sat;
   logic                w_quiet_hit;
   logic                w_rst_active;
   logic                w_lockout;

   assign w_req       = core_reset_req_i | sw_reset_req_i;
   assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
   assign w_lock_hit  = LOCKOUT_EN & (r_consec_cnt >= CONSEC_W'(MAX_RESETS));
   assign w_quiet_sat = (r_quiet_cnt == QUIET_W'(QUIET_CYCLES));
   assign w_quiet_hit = (r_quiet_cnt == QUIET_W'(QUIET_CYCLES - 1));

   // State register; reset lands in HOLD so the power-on hold runs like any other.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) r_state <= ST_HOLD;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_req) w_state_next = ST_HOLD;
         ST_HOLD:    if (w_hold_done) w_state_next = w_lock_hit ? ST_LOCK : ST_RELEASE;
         ST_RELEASE: if (!core_reset_req_i) w_state_next = ST_IDLE;
         ST_LOCK: begin
            // Without lockout LOCK is an illegal code and recovers through HOLD.
            if (!LOCKOUT_EN) w_state_next = ST_HOLD;
            else if (w_clr)  w_state_next = ST_RELEASE;
         end
         default:    w_state_next = ST_HOLD;
      endcase
   end

   always_comb begin
      w_rst_active = 1'b0;
      w_lockout    = 1'b0;
      case (r_state)
         ST_HOLD: w_rst_active = 1'b1;
         ST_LOCK: begin
            w_rst_active = 1'b1;
            w_lockout    = LOCKOUT_EN;
         end
         default: ;
      endcase
   end

   // Hold timer, quiet window and the two saturating reset counters.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_hold_cnt   <= '0;
         r_quiet_cnt  <= '0;
         r_reset_cnt  <= '0;
         r_consec_cnt <= '0;
      end else begin
         r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + HOLD_W'(1) : '0;

         if (r_state == ST_IDLE && !w_req) begin
            if (!w_quiet_sat) r_quiet_cnt <= r_quiet_cnt + QUIET_W'(1);
         end else begin
            r_quiet_cnt <= '0;
         end

         // A request beats a quiet-window clear landing on the same cycle.
         if (r_state == ST_IDLE && w_req) begin
            if (r_reset_cnt != '1)  r_reset_cnt  <= r_reset_cnt + RST_W'(1);
            if (r_consec_cnt != '1) r_consec_cnt <= r_consec_cnt + CONSEC_W'(1);
         end else if (r_state == ST_IDLE && w_quiet_hit) begin
            r_consec_cnt <= '0;
         end else if (r_state == ST_LOCK && LOCKOUT_EN && w_clr) begin
            r_consec_cnt <= '0;
         end
      end
   end

   assign core_rst_no  = ~arst_i & ~w_rst_active;
   assign rst_active_o = w_rst_active;
   assign lockout_o    = w_lockout;
   assign reset_cnt_o  = r_reset_cnt;
   assign consec_cnt_o = r_consec_cnt;

endmodule

// File: tb/tb_fatori_rst_ctrl.sv
// Self-checking bench for fatori_rst_ctrl with HOLD=4, MAX_RESETS=3, QUIET=8.
module tb_fatori_rst_ctrl;

   localparam int HOLD  = 4;
   localparam int MAXR  = 3;
   localparam int QUIET = 8;
`ifdef FATORI_RST_CTRL_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       arst_i = 1'b1;
   logic       core_reset_req_i = 1'b0;
   logic       sw_reset_req_i = 1'b0;
   logic       clr_lockout_i = 1'b0;
   logic       core_rst_no;
   logic       rst_active_o;
   logic [7:0] reset_cnt_o;
   logic [3:0] consec_cnt_o;
   logic       lockout_o;

   int errors = 0;
   int checks = 0;

   fatori_rst_ctrl #(.HOLD_CYCLES(HOLD), .MAX_RESETS(MAXR), .QUIET_CYCLES(QUIET)) dut (
      .clk_i            (clk_i),
      .arst_i           (arst_i),
      .core_reset_req_i (core_reset_req_i),
      .sw_reset_req_i   (sw_reset_req_i),
      .clr_lockout_i    (clr_lockout_i),
      .core_rst_no      (core_rst_no),
      .rst_active_o     (rst_active_o),
      .reset_cnt_o      (reset_cnt_o),
      .consec_cnt_o     (consec_cnt_o),
      .lockout_o        (lockout_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural model: phase plus a countdown of remaining hold cycles.
   typedef enum {M_IDLE, M_HOLD, M_RELEASE, M_LOCK} mphase_t;
   mphase_t m_phase = M_HOLD;
   int m_hold_left = HOLD;
   int m_quiet = 0;
   int m_rc = 0;
   int m_cc = 0;

   function automatic void model_reset();
      m_phase = M_HOLD; m_hold_left = HOLD; m_quiet = 0; m_rc = 0; m_cc = 0;
   endfunction

   function automatic void model_step(bit creq, bit sreq, bit clr);
      case (m_phase)
         M_IDLE: begin
            if (creq || sreq) begin
               m_phase = M_HOLD; m_hold_left = HOLD; m_quiet = 0;
               m_rc = (m_rc < 255) ? m_rc + 1 : 255;
               m_cc = (m_cc < 15) ? m_cc + 1 : 15;
            end else if (m_quiet < QUIET) begin
               m_quiet = m_quiet + 1;
               if (m_quiet == QUIET) m_cc = 0;
            end
         end
         M_HOLD: begin
            m_quiet = 0;
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) m_phase = (LOCK_EN && m_cc >= MAXR) ? M_LOCK : M_RELEASE;
         end
         M_RELEASE: begin
            m_quiet = 0;
            if (!creq) m_phase = M_IDLE;
         end
         M_LOCK: begin
            m_quiet = 0;
            if (clr) begin m_phase = M_RELEASE; m_cc = 0; end
         end
      endcase
   endfunction

   function automatic logic [14:0] exp_vec();
      logic act;
      act = (m_phase == M_HOLD) || (m_phase == M_LOCK);
      return {~arst_i & ~act, act, (m_phase == M_LOCK), 8'(m_rc), 4'(m_cc)};
   endfunction

   function automatic logic [14:0] obs_vec();
      return {core_rst_no, rst_active_o, lockout_o, reset_cnt_o, consec_cnt_o};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      if (arst_i) model_reset();
      else model_step(core_reset_req_i, sw_reset_req_i, clr_lockout_i);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      core_reset_req_i = 1'b0; sw_reset_req_i = 1'b0; clr_lockout_i = 1'b0;
      arst_i = 1'b1;
      model_reset();
      tick(); tick();
      arst_i = 1'b0;
   endtask

   task automatic test_reset();
      logic exp_core;
      tick(); tick();
      if (obs_vec() !== 15'b0_1_0_00000000_0000) begin
         errors++; $display("FAIL reset_values got=%h exp=%h", obs_vec(), 15'b0_1_0_00000000_0000);
      end
      checks++;
      arst_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_core = (i == 4);
         if (core_rst_no !== exp_core || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL por_hold cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
         checks++;
         if (i < 4) tick();
      end
      if (reset_cnt_o !== 8'd0 || consec_cnt_o !== 4'd0) begin
         errors++; $display("FAIL por_counters got=%0d/%0d exp=0/0", reset_cnt_o, consec_cnt_o);
      end
      checks++;
   endtask

   task automatic test_sw_pulse();
      do_reset();
      repeat (7) tick();
      sw_reset_req_i = 1'b1; tick(); sw_reset_req_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (core_rst_no !== (i >= 4) || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL sw_pulse cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
         checks++;
         tick();
      end
      if (reset_cnt_o !== 8'd1 || consec_cnt_o !== 4'd1) begin
         errors++; $display("FAIL sw_counts got=%0d/%0d exp=1/1", reset_cnt_o, consec_cnt_o);
      end
      checks++;
   endtask

   task automatic test_level_req();
      do_reset();
      repeat (7) tick();
      core_reset_req_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL level_req cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
         checks++;
      end
      core_reset_req_i = 1'b0;
      repeat (3) tick();
      if (reset_cnt_o !== 8'd1 || core_rst_no !== 1'b1) begin
         errors++; $display("FAIL level_once got=%0d/%b exp=1/1", reset_cnt_o, core_rst_no);
      end
      checks++;
   endtask

   task automatic test_lockout();
      do_reset();
      repeat (7) tick();
      for (int k = 0; k < 3; k++) begin
         sw_reset_req_i = 1'b1; tick(); sw_reset_req_i = 1'b0;
         for (int i = 0; i < ((k < 2) ? 9 : 4); i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
               errors++; $display("FAIL lockout_seq k=%0d cyc=%0d got=%h exp=%h", k, i, obs_vec(), exp_vec());
            end
            checks++;
         end
      end
      if (consec_cnt_o !== 4'd3 || lockout_o !== LOCK_EN || core_rst_no !== !LOCK_EN) begin
         errors++; $display("FAIL lock_entry got=%0d/%b/%b exp=3/%b/%b",
                            consec_cnt_o, lockout_o, core_rst_no, LOCK_EN, !LOCK_EN);
      end
      checks++;
      repeat (3) tick();
      clr_lockout_i = 1'b1; tick(); clr_lockout_i = 1'b0;
      if (consec_cnt_o !== (LOCK_EN ? 4'd0 : 4'd3) || reset_cnt_o !== 8'd3 || lockout_o !== 1'b0 ||
          core_rst_no !== 1'b1 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL lock_clear got=%h exp=%h", obs_vec(), exp_vec());
      end
      checks++;
   endtask

   task automatic test_quiet();
      for (int v = 0; v < 2; v++) begin
         do_reset();
         repeat (8) tick();
         sw_reset_req_i = 1'b1; tick(); sw_reset_req_i = 1'b0;
         repeat (9) tick();
         sw_reset_req_i = 1'b1; tick(); sw_reset_req_i = 1'b0;
         repeat (5) tick();
         if (consec_cnt_o !== 4'd2) begin
            errors++; $display("FAIL quiet_two v=%0d got=%0d exp=2", v, consec_cnt_o);
         end
         checks++;
         repeat (7) tick();
         if (v == 0) begin
            tick();
            if (consec_cnt_o !== 4'd0 || obs_vec() !== exp_vec()) begin
               errors++; $display("FAIL quiet_clear got=%0d exp=0", consec_cnt_o);
            end
            checks++;
         end
         sw_reset_req_i = 1'b1; tick(); sw_reset_req_i = 1'b0;
         if (consec_cnt_o !== ((v == 0) ? 4'd1 : 4'd3)) begin
            errors++; $display("FAIL quiet_third v=%0d got=%0d exp=%0d", v, consec_cnt_o, (v == 0) ? 1 : 3);
         end
         checks++;
         repeat (4) tick();
         if (lockout_o !== ((v == 1) && LOCK_EN) || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL quiet_lock v=%0d got=%b exp=%b", v, lockout_o, (v == 1) && LOCK_EN);
         end
         checks++;
      end
   endtask

   task automatic test_back_to_back();
      bit saw_lock = 1'b0;
      int budget = 0;
      do_reset();
      repeat (6) tick();
      sw_reset_req_i = 1'b1; clr_lockout_i = 1'b1;
      while (m_rc < 20 && budget < 500) begin
         tick(); budget++;
         if (lockout_o === 1'b1) saw_lock = 1'b1;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", budget, obs_vec(), exp_vec());
         end
         checks++;
      end
      sw_reset_req_i = 1'b0; clr_lockout_i = 1'b0;
      if (budget >= 500) begin
         errors++; $display("FAIL b2b_timeout got=%0d requests exp=20", m_rc);
      end
      repeat (6) tick();
      if (reset_cnt_o !== 8'd20 || (!LOCK_EN && (consec_cnt_o !== 4'd15 || saw_lock))) begin
         errors++; $display("FAIL b2b_final got=%0d/%0d/%b exp=20/15/0", reset_cnt_o, consec_cnt_o, saw_lock);
      end
      checks++;
   endtask

   task automatic test_saturation();
      int budget = 0;
      int extra = 0;
      sw_reset_req_i = 1'b1; clr_lockout_i = 1'b1;
      while (extra < 12 && budget < 3000) begin
         tick(); budget++;
         if (m_rc == 255 && m_phase == M_HOLD && m_hold_left == HOLD) extra++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL sat cyc=%0d got=%h exp=%h", budget, obs_vec(), exp_vec());
         end
         checks++;
      end
      sw_reset_req_i = 1'b0; clr_lockout_i = 1'b0;
      if (budget >= 3000) begin
         errors++; $display("FAIL sat_timeout got=%0d exp=255", m_rc);
      end
      if (reset_cnt_o !== 8'd255) begin
         errors++; $display("FAIL sat_value got=%0d exp=255", reset_cnt_o);
      end
      checks++;
   endtask

   task automatic test_abort();
      do_reset();
      repeat (7) tick();
      core_reset_req_i = 1'b1;
      repeat (7) tick();
      #2 arst_i = 1'b1;
      #1;
      if (core_rst_no !== 1'b0 || rst_active_o !== 1'b1 || reset_cnt_o !== 8'd0) begin
         errors++; $display("FAIL abort_release got=%b/%b/%0d exp=0/1/0", core_rst_no, rst_active_o, reset_cnt_o);
      end
      checks++;
      core_reset_req_i = 1'b0;
      model_reset();
      tick();
      arst_i = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (core_reset_req_i) core_reset_req_i = ($urandom_range(0, 2) != 0);
         else core_reset_req_i = ($urandom_range(0, 14) == 0);
         sw_reset_req_i = ($urandom_range(0, 19) == 0);
         clr_lockout_i  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #2 arst_i = 1'b1;
            #1;
            if (core_rst_no !== 1'b0 || rst_active_o !== 1'b1 || lockout_o !== 1'b0 || consec_cnt_o !== 4'd0) begin
               errors++; $display("FAIL rnd_abort cyc=%0d got=%b/%b/%b/%0d exp=0/1/0/0",
                                  i, core_rst_no, rst_active_o, lockout_o, consec_cnt_o);
            end
            checks++;
            model_reset();
            tick();
            arst_i = 1'b0;
         end else begin
            tick();
         end
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rnd cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
         checks++;
      end
      core_reset_req_i = 1'b0; sw_reset_req_i = 1'b0; clr_lockout_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sw_pulse();
      test_level_req();
      test_lockout();
      test_quiet();
      test_back_to_back();
      test_saturation();
      test_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fatori_rst_ctrl.md
FATORI_RST_CTRL -- requirements
Module: fatori_rst_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles core_rst_no is held low per reset (1..255).
REQ-002 SHALL have parameter MAX_RESETS, default 3: consecutive resets before lockout (1..15).
REQ-003 SHALL have parameter QUIET_CYCLES, default 1024: fault-free IDLE cycles that clear the consecutive count (1..65535).
REQ-004 SHALL have port clk_i, input, 1: single clock; all state rises on clk_i.
REQ-005 SHALL have port arst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port core_reset_req_i, input, 1: level reset request from the fault manager.
REQ-007 SHALL have port sw_reset_req_i, input, 1: single-cycle software reset request.
REQ-008 SHALL have port clr_lockout_i, input, 1: single-cycle lockout release.
REQ-009 SHALL have port core_rst_no, output, 1: active-low reset to core and fault manager.
REQ-010 SHALL have port rst_active_o, output, 1: high in HOLD or LOCK.
REQ-011 SHALL have port reset_cnt_o, output, 8: total requested resets issued, saturating at 255.
REQ-012 SHALL have port consec_cnt_o, output, 4: consecutive resets since the last quiet window, saturating at 15.
REQ-013 SHALL have port lockout_o, output, 1: high in LOCK.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, RELEASE and LOCK in 2-bit encoding; unused codes SHALL go to HOLD on the next cycle.
REQ-015 SHALL drive core_rst_no = !arst_i & !(state==HOLD | state==LOCK), so core reset propagates combinationally during arst_i.
REQ-016 IDLE: SHALL enter HOLD if core_reset_req_i | sw_reset_req_i, clear hold_cnt, and increment reset_cnt_o and consec_cnt_o, both saturating.
REQ-017 HOLD: SHALL increment hold_cnt each cycle and exit after exactly HOLD_CYCLES cycles in HOLD.
REQ-018 HOLD exit: SHALL go to LOCK if lockout is compiled in and consec_cnt_o >= MAX_RESETS; otherwise it SHALL go to RELEASE.
REQ-019 RELEASE: SHALL go to IDLE on the first cycle core_reset_req_i is low; while that input is high, the state SHALL stay in RELEASE with core_rst_no high.
REQ-020 LOCK: SHALL hold until clr_lockout_i is high, then go to RELEASE with consec_cnt_o cleared to 0; reset_cnt_o SHALL be unchanged.
REQ-021 sw_reset_req_i SHALL be ignored outside IDLE; clr_lockout_i SHALL be ignored outside LOCK.
REQ-022 Quiet counter: SHALL count cycles in IDLE with no request, saturating at QUIET_CYCLES.
REQ-023 Quiet counter: on the cycle it reaches QUIET_CYCLES, consec_cnt_o SHALL clear to 0.
REQ-024 Quiet counter: SHALL clear to 0 on any cycle outside IDLE.
REQ-025 On a request in the same cycle the quiet count reaches threshold, the request SHALL win: consec_cnt_o = old value + 1, with no clear.
REQ-026 Counter widths SHALL be sized $clog2(param+1); arithmetic SHALL be unsigned with no wrap on the saturating counters.

Reset
REQ-027 While arst_i is high: state = HOLD, hold_cnt = 0, quiet count = 0, reset_cnt_o = 0, consec_cnt_o = 0, lockout_o = 0, rst_active_o = 1, core_rst_no = 0.
REQ-028 After arst_i falls: SHALL complete a power-on HOLD of HOLD_CYCLES cycles, then go to RELEASE; this HOLD SHALL not increment any counter and SHALL never lead to LOCK.
REQ-029 arst_i asserted mid-HOLD, RELEASE or LOCK SHALL abort immediately into the REQ-027 values, including leaving LOCK.

Configuration
REQ-030 Macro FATORI_RST_CTRL_LOCKOUT_EN defined: LOCK state, lockout_o and clr_lockout_i SHALL be functional as specified.
REQ-031 Macro FATORI_RST_CTRL_LOCKOUT_EN undefined: LOCK SHALL be unreachable, HOLD SHALL always exit to RELEASE, lockout_o SHALL be tied 0, and clr_lockout_i SHALL be unused; the counters SHALL be unchanged.

Verification (HOLD_CYCLES=4, MAX_RESETS=3, QUIET_CYCLES=8)
REQ-032 Release arst_i -> core_rst_no stays 0 for exactly 4 cycles, then 1; counters = 0.
REQ-033 Pulse sw_reset_req_i in IDLE -> core_rst_no low 4 cycles from the next edge; reset_cnt_o=1, consec_cnt_o=1.
REQ-034 Hold core_reset_req_i high for 10 cycles -> one HOLD, then RELEASE until the input drops; reset_cnt_o=1 only.
REQ-035 Three requests spaced 5 IDLE cycles apart -> third HOLD exits to LOCK with lockout_o=1 and core_rst_no=0; pulse clr_lockout_i -> RELEASE, consec_cnt_o=0, reset_cnt_o=3.
REQ-036 Two requests, then 8 quiet cycles, then a third -> consec_cnt_o goes 2, then 0, then 1, with no lockout; a request on the 8th quiet cycle instead -> consec_cnt_o=3 and LOCK.
REQ-037 Build without FATORI_RST_CTRL_LOCKOUT_EN, 20 back-to-back requests -> never LOCK; lockout_o=0, consec_cnt_o=15, reset_cnt_o=20.
